// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory op encoding, FSM state codes,
// reset level and small op-decode helpers.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Level of rst that holds the stage in reset.
  localparam logic RESET_ENABLE = 1'b0;

  // Unknown op codes fall back to a full-word load so the FSM never stalls forever.
  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
      default:                 return 3'd4;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result formatting: picks byte/half/word from the assembled little-endian
// buffer and sign- or zero-extends it. Also used by the forwarding path.
module mem_load_ext
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = word;
    case (op)
      MEM_LB:  result = {{(DATA_W-8){word[7]}}, word[7:0]};
      MEM_LBU: result = {{(DATA_W-8){1'b0}}, word[7:0]};
      MEM_LH:  result = {{(DATA_W-16){word[15]}}, word[15:0]};
      MEM_LHU: result = {{(DATA_W-16){1'b0}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: turns loads/stores into byte-serial accesses on the shared 8-bit
// RAM port and passes ALU results through with one registered cycle.
//
// state  | meaning
// IDLE   | accept next EX result; ALU ops pass straight through
// ACCESS | issue bytes behind the grant, collect read returns
// DONE   | one-cycle writeback pulse, stall already released
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o
);

  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic [DATA_W-1:0] byte_buf;
  logic [DATA_W-1:0] buf_next;
  logic [DATA_W-1:0] ext_data;
  logic [4:0]        rd_q;
  logic              en_q;
  logic [2:0]        issued;
  logic [2:0]        returned;
  logic [2:0]        n_bytes;
  logic              ret_q;
  logic              is_store;
  logic              issue;
  logic              store_done;
  logic              load_done;

  assign n_bytes     = op_bytes(op_q);
  assign is_store    = op_is_store(op_q);
  assign stall_o     = (state == ST_ACCESS) ||
                       ((state == ST_IDLE) && valid_i && (mem_op_i != MEM_NONE));
  assign mem_req_o   = (state == ST_ACCESS) && (issued < n_bytes);
  assign mem_we_o    = mem_req_o && is_store;
  assign mem_addr_o  = addr_q + ADDR_W'(issued);
  assign mem_wdata_o = store_q[{issued[1:0], 3'b000} +: 8];
  assign issue       = mem_req_o && mem_gnt_i;
  assign store_done  = is_store && issue && (issued == n_bytes - 3'd1);
  assign load_done   = !is_store && ret_q && (returned == n_bytes - 3'd1);

  // Merge the byte arriving this cycle so the final byte reaches DONE without an extra cycle.
  always_comb begin
    buf_next = byte_buf;
    if (ret_q) buf_next[{returned[1:0], 3'b000} +: 8] = mem_rdata_i;
  end

  mem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .word   (buf_next),
    .op     (op_q),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_ENABLE) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      store_q     <= '0;
      byte_buf    <= '0;
      rd_q        <= '0;
      en_q        <= 1'b0;
      issued      <= '0;
      returned    <= '0;
      ret_q       <= 1'b0;
      valid_o     <= 1'b0;
      rd_data_o   <= '0;
      rd_addr_o   <= '0;
      rd_enable_o <= 1'b0;
    end else begin
      ret_q       <= issue && !mem_we_o;
      valid_o     <= 1'b0;
      rd_enable_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (mem_op_i == MEM_NONE) begin
              valid_o     <= 1'b1;
              rd_data_o   <= rd_data_i;
              rd_addr_o   <= rd_addr_i;
              rd_enable_o <= rd_enable_i;
            end else begin
              op_q     <= mem_op_i;
              addr_q   <= mem_addr_i;
              store_q  <= store_data_i;
              rd_q     <= rd_addr_i;
              en_q     <= rd_enable_i;
              issued   <= '0;
              returned <= '0;
              byte_buf <= '0;
              state    <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (issue) issued <= issued + 3'd1;
          if (ret_q) begin
            byte_buf <= buf_next;
            returned <= returned + 3'd1;
          end
          if (store_done || load_done) begin
            state       <= ST_DONE;
            valid_o     <= 1'b1;
            rd_addr_o   <= rd_q;
            rd_enable_o <= is_store ? 1'b0 : en_q;
            rd_data_o   <= is_store ? '0 : ext_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a byte-addressed RAM model answers the port,
// and a transaction-level reference predicts timing, bus bytes and results.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic [31:0] rd_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_enable_i = 1'b0;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic        valid_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ram [logic [31:0]];
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .rd_data_i    (rd_data_i),
    .rd_addr_i    (rd_addr_i),
    .rd_enable_i  (rd_enable_i),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rdata_i  (mem_rdata_i),
    .valid_o      (valid_o),
    .rd_data_o    (rd_data_o),
    .rd_addr_o    (rd_addr_o),
    .rd_enable_o  (rd_enable_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (!ram.exists(a)) ram[a] = 8'($urandom);
    return ram[a];
  endfunction

  function automatic int ref_bytes(input logic [3:0] op);
    if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
    return 4;
  endfunction

  // Value as the ISA defines it: little-endian integer, signed for LB/LH.
  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
    longint v = 0;
    int n = ref_bytes(op);
    for (int i = 0; i < n; i++) v += longint'(mem_byte(addr + 32'(i))) << (8 * i);
    if (op == MEM_LB && v >= 128)   v -= 256;
    if (op == MEM_LH && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  task automatic drive_rdata();
    mem_rdata_i = pend ? mem_byte(paddr) : 8'($urandom);
    pend = 1'b0;
  endtask

  task automatic run_alu(input logic [31:0] data, input logic [4:0] rd, input logic en);
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = MEM_NONE; rd_data_i = data; rd_addr_i = rd; rd_enable_i = en;
    #1 check_val("alu_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    check_val("alu_stall1", 32'(stall_o), 32'd0);
    check_val("alu_valid", 32'(valid_o), 32'd1);
    check_val("alu_data", rd_data_o, data);
    check_val("alu_rd", 32'(rd_addr_o), 32'(rd));
    check_val("alu_en", 32'(rd_enable_o), 32'(en));
    @(negedge clk);
    check_val("alu_valid_end", 32'(valid_o), 32'd0);
  endtask

  // gmode: 0 = grant always, 1 = random grant, 2 = grant low in cycles 2-3.
  // abort_at > 0: assert reset asynchronously once that many bytes were granted.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input logic en, input int gmode, input int abort_at);
    bit          gp [64];
    int          n, cnt, last, expv, issued;
    bit          st;
    logic [31:0] exp_data;
    n  = ref_bytes(op);
    st = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
    for (int k = 0; k < 64; k++) begin
      if (k >= 30 || gmode == 0) gp[k] = 1'b1;
      else if (gmode == 1)       gp[k] = ($urandom_range(0, 2) != 0);
      else                       gp[k] = !(k == 2 || k == 3);
    end
    cnt = 0; last = 0;
    for (int k = 1; k < 64; k++)
      if (gp[k]) begin
        cnt++;
        if (cnt == n && last == 0) last = k;
      end
    expv     = st ? last + 1 : last + 2;
    exp_data = st ? 32'd0 : ref_load(op, addr);

    @(negedge clk);
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; store_data_i = sd;
    rd_data_i = $urandom; rd_addr_i = rd; rd_enable_i = en; mem_gnt_i = 1'b0;
    #1 check_val("stall_accept", 32'(stall_o), 32'd1);
    @(posedge clk); #1 drive_rdata();
    issued = 0;
    for (int c = 1; c <= expv + 1; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      check_val("stall", 32'(stall_o), 32'(c < expv));
      check_val("valid", 32'(valid_o), 32'(c == expv));
      check_val("req", 32'(mem_req_o), 32'(issued < n));
      if (mem_req_o) begin
        check_val("addr", mem_addr_o, addr + 32'(issued));
        check_val("we", 32'(mem_we_o), 32'(st));
        if (st) check_val("wdata", 32'(mem_wdata_o), (sd >> (8 * issued)) & 32'hFF);
      end
      if (c == expv) begin
        check_val("rd_data", rd_data_o, exp_data);
        check_val("rd_addr", 32'(rd_addr_o), 32'(rd));
        check_val("rd_en", 32'(rd_enable_o), st ? 32'd0 : 32'(en));
      end else if (c > expv) begin
        check_val("rd_en_idle", 32'(rd_enable_o), 32'd0);
      end
      mem_gnt_i = gp[c];
      if (mem_req_o && mem_gnt_i) begin
        if (mem_we_o) ram[mem_addr_o] = mem_wdata_o;
        else begin pend = 1'b1; paddr = mem_addr_o; end
        issued++;
      end
      if (abort_at > 0 && issued == abort_at) begin
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check_val("rst_req", 32'(mem_req_o), 32'd0);
        check_val("rst_stall", 32'(stall_o), 32'd0);
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_addr", mem_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b1; mem_gnt_i = 1'b0; pend = 1'b0;
        return;
      end
      @(posedge clk); #1 drive_rdata();
    end
    mem_gnt_i = 1'b0;
    if (st)
      for (int i = 0; i < n; i++)
        check_val("st_mem", 32'(mem_byte(addr + 32'(i))), (sd >> (8 * i)) & 32'hFF);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check_val("reset_stall", 32'(stall_o), 32'd0);
    check_val("reset_req", 32'(mem_req_o), 32'd0);
    check_val("reset_we", 32'(mem_we_o), 32'd0);
    check_val("reset_addr", mem_addr_o, 32'd0);
    check_val("reset_wdata", 32'(mem_wdata_o), 32'd0);
    check_val("reset_valid", 32'(valid_o), 32'd0);
    check_val("reset_rd_data", rd_data_o, 32'd0);
    check_val("reset_rd_addr", 32'(rd_addr_o), 32'd0);
    check_val("reset_rd_en", 32'(rd_enable_o), 32'd0);
    rst = 1'b1;

    run_alu(32'h1234_5678, 5'd5, 1'b1);

    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    run_op(MEM_LW, 32'h100, 32'h0, 5'd7, 1'b1, 0, 0);
    ram[32'h200] = 8'h80;
    run_op(MEM_LB, 32'h200, 32'h0, 5'd8, 1'b1, 0, 0);
    run_op(MEM_LBU, 32'h200, 32'h0, 5'd9, 1'b1, 0, 0);
    ram[32'h201] = 8'hFF; ram[32'h202] = 8'h7F;
    run_op(MEM_LH, 32'h201, 32'h0, 5'd10, 1'b1, 0, 0);
    run_op(MEM_SW, 32'h300, 32'hDEAD_BEEF, 5'd3, 1'b1, 2, 0);
    run_op(MEM_SH, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd4, 1'b1, 0, 0);
    run_op(MEM_LW, 32'h400, 32'h0, 5'd11, 1'b1, 0, 2);
    ram[32'h500] = 8'h5A;
    run_op(MEM_LB, 32'h500, 32'h0, 5'd12, 1'b1, 0, 0);

    for (int t = 0; t < 150; t++) begin
      op = 4'($urandom_range(0, 8));
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                       : 32'($urandom_range(0, 255));
      if (op == MEM_NONE) run_alu($urandom, 5'($urandom), 1'($urandom));
      else run_op(op, a, $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
